cache_ctrl: RTL and testbench

Sequencing controller for the direct-mapped read cache. It accepts CPU read requests over a valid/ready handshake and performs the tag/valid lookup against its internal line store. On a miss it refills the whole line from main memory over a request/beat handshake, then returns the requested word with a hit flag. It also keeps saturating hit/miss statistics and supports a one-cycle flush.

---
 rtl/cache_ctrl_pkg.sv | 24 ++
 rtl/cache_sat_counter.sv | 24 ++
 rtl/cache_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_cache_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the direct-mapped read cache controller:
// FSM state encoding and helpers that derive the address-field widths.
package cache_ctrl_pkg;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOOKUP  = 3'd1,
        S_MEM_REQ = 3'd2,
        S_REFILL  = 3'd3,
        S_RESPOND = 3'd4
    } state_t;

    // Tag width: everything above index, word offset and the 2 byte-offset bits.
    function automatic int tag_width(input int addr_w, input int index_w, input int offset_w);
        return addr_w - index_w - offset_w - 2;
    endfunction

    // Number of lines in the line store.
    function automatic int line_count(input int index_w);
        return 1 << index_w;
    endfunction

endpackage

// File: rtl/cache_sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
module cache_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    // Increment on each event unless already saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped read cache controller: lookup, whole-line refill on miss,
// single-cycle response strobe, one-cycle flush and hit/miss statistics.
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 2,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_hit,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    input  logic              flush,
    output logic              busy,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int TAG_W = tag_width(ADDR_W, INDEX_W, OFFSET_W);
    localparam int LINES = line_count(INDEX_W);
    localparam int WORDS = 1 << OFFSET_W;
    localparam int DA_W  = INDEX_W + OFFSET_W;

    // Address field extraction for the incoming request.
    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_idx;
    logic [OFFSET_W-1:0] req_word;
    logic [1:0]          unused_byte_bits;

    assign req_tag          = req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx          = req_addr[OFFSET_W+2 +: INDEX_W];
    assign req_word         = req_addr[2 +: OFFSET_W];
    assign unused_byte_bits = req_addr[1:0];

    // State and datapath registers.
    state_t              state_reg, state_next;
    logic [TAG_W-1:0]    tag_reg;
    logic [INDEX_W-1:0]  idx_reg;
    logic [OFFSET_W-1:0] word_reg;
    logic [OFFSET_W-1:0] beat_reg;
    logic [LINES-1:0]    valid_reg, valid_next;
    logic [TAG_W-1:0]    rd_tag_reg;
    logic [DATA_W-1:0]   rd_word_reg;
    logic [DATA_W-1:0]   pend_data_reg;
    logic                pend_hit_reg;
    logic                resp_valid_reg;
    logic [DATA_W-1:0]   resp_data_reg;
    logic                resp_hit_reg;
    logic                mem_req_valid_reg;
    logic [ADDR_W-1:0]   mem_req_addr_reg;

    // Line store: tags per line, data words addressed by {index, word}.
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [1 << DA_W];

    // Decoded control strobes.
    logic accept, flush_now, lookup_hit, hit_inc, miss_inc, beat_wr, last_beat;

    assign flush_now  = (state_reg == S_IDLE) && flush;
    assign accept     = (state_reg == S_IDLE) && req_valid && !flush;
    assign lookup_hit = valid_reg[idx_reg] && (rd_tag_reg == tag_reg);
    assign hit_inc    = (state_reg == S_LOOKUP) && lookup_hit;
    assign miss_inc   = (state_reg == S_LOOKUP) && !lookup_hit;
    assign beat_wr    = (state_reg == S_REFILL) && mem_resp_valid;
    assign last_beat  = beat_wr && (beat_reg == {OFFSET_W{1'b1}});

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (accept) state_next = S_LOOKUP;
            S_LOOKUP:  state_next = lookup_hit ? S_RESPOND : S_MEM_REQ;
            S_MEM_REQ: if (mem_req_valid_reg && mem_req_ready) state_next = S_REFILL;
            S_REFILL:  if (last_beat) state_next = S_RESPOND;
            S_RESPOND: state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Per-line valid bit: flush clears all, a miss clears the victim line
    // so a refill interrupted by reset leaves it invalid, a completed refill sets it.
    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
            assign valid_next[gi] = flush_now ? 1'b0 :
                                    (miss_inc  && (idx_reg == INDEX_W'(gi))) ? 1'b0 :
                                    (last_beat && (idx_reg == INDEX_W'(gi))) ? 1'b1 :
                                    valid_reg[gi];
        end
    endgenerate

    // Valid bit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= valid_next;
        end
    end

    // Line store writes during refill and registered read of tag/word at accept.
    always_ff @(posedge clk) begin
        if (beat_wr) begin
            data_mem[{idx_reg, beat_reg}] <= mem_resp_data;
        end
        if (last_beat) begin
            tag_mem[idx_reg] <= tag_reg;
        end
        if (accept) begin
            rd_tag_reg  <= tag_mem[req_idx];
            rd_word_reg <= data_mem[{req_idx, req_word}];
        end
    end

    // Request latch, memory request handshake, beat counter and response staging.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_reg           <= '0;
            idx_reg           <= '0;
            word_reg          <= '0;
            beat_reg          <= '0;
            pend_data_reg     <= '0;
            pend_hit_reg      <= 1'b0;
            resp_valid_reg    <= 1'b0;
            resp_data_reg     <= '0;
            resp_hit_reg      <= 1'b0;
            mem_req_valid_reg <= 1'b0;
            mem_req_addr_reg  <= '0;
        end else begin
            resp_valid_reg <= 1'b0;
            if (accept) begin
                tag_reg  <= req_tag;
                idx_reg  <= req_idx;
                word_reg <= req_word;
            end
            if (hit_inc) begin
                pend_data_reg <= rd_word_reg;
                pend_hit_reg  <= 1'b1;
            end
            if (miss_inc) begin
                pend_hit_reg      <= 1'b0;
                mem_req_valid_reg <= 1'b1;
                mem_req_addr_reg  <= {tag_reg, idx_reg, {(OFFSET_W + 2){1'b0}}};
            end
            if ((state_reg == S_MEM_REQ) && mem_req_valid_reg && mem_req_ready) begin
                mem_req_valid_reg <= 1'b0;
                beat_reg          <= '0;
            end
            if (beat_wr) begin
                beat_reg <= beat_reg + 1'b1;
                if (beat_reg == word_reg) begin
                    pend_data_reg <= mem_resp_data;
                end
            end
            // Response fields update together with the strobe so they hold between responses.
            if (state_reg == S_RESPOND) begin
                resp_valid_reg <= 1'b1;
                resp_data_reg  <= pend_data_reg;
                resp_hit_reg   <= pend_hit_reg;
            end
        end
    end

    cache_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hit_inc),
        .count (hit_count)
    );

    cache_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (miss_inc),
        .count (miss_count)
    );

    assign req_ready     = (state_reg == S_IDLE) && !flush;
    assign busy          = (state_reg != S_IDLE);
    assign resp_valid    = resp_valid_reg;
    assign resp_data     = resp_data_reg;
    assign resp_hit      = resp_hit_reg;
    assign mem_req_valid = mem_req_valid_reg;
    assign mem_req_addr  = mem_req_addr_reg;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: miss/hit sequencing, flush, memory
// backpressure and beat gaps, stray beats and reset during refill.
`timescale 1ns/1ps
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_hit;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_hit       (resp_hit),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .flush          (flush),
        .busy           (busy),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    // Issue one read and act as main memory; reports what was observed.
    task automatic do_read(input logic [31:0] addr, input logic [31:0] base,
                           input int hold, input int gap,
                           output logic [31:0] rdata, output logic rhit,
                           output logic mreq_seen, output logic [31:0] maddr,
                           output int lat, output int mlat,
                           output logic stable, output logic timeout);
        time  t0;
        logic served;
        rdata = '0; rhit = 1'b0; mreq_seen = 1'b0; maddr = '0;
        lat = -1; mlat = -1; stable = 1'b1; timeout = 1'b1; served = 1'b0;
        req_valid = 1'b1;
        req_addr  = addr;
        @(posedge clk);
        t0 = $time;
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (resp_valid) begin
                rdata   = resp_data;
                rhit    = resp_hit;
                lat     = int'(($time - t0 - 1) / 10);
                timeout = 1'b0;
                break;
            end
            if (mem_req_valid && !served) begin
                served    = 1'b1;
                mreq_seen = 1'b1;
                maddr     = mem_req_addr;
                mlat      = int'(($time - t0 - 1) / 10);
                for (int h = 0; h < hold; h++) begin
                    @(posedge clk); #1;
                    if (!mem_req_valid || (mem_req_addr !== maddr)) stable = 1'b0;
                end
                mem_req_ready = 1'b1;
                @(posedge clk); #1;
                mem_req_ready = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    for (int g = 0; g < gap; g++) begin
                        @(posedge clk); #1;
                    end
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = base + 32'(k);
                    @(posedge clk); #1;
                    mem_resp_valid = 1'b0;
                end
            end else begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({resp_valid, resp_hit, mem_req_valid, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {resp_valid, resp_hit, mem_req_valid, busy});
        end
        checks++;
        if ({resp_data, mem_req_addr, hit_count, miss_count} !== 128'd0) begin
            errors++;
            $display("FAIL reset_values data=%h maddr=%h hits=%0d misses=%0d want all 0",
                     resp_data, mem_req_addr, hit_count, miss_count);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready got %b want 1", req_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_miss_then_hit();
        logic [31:0] d, ma; logic h, seen, st, to; int lat, mlat;
        do_read(32'h14, 32'hA0, 0, 0, d, h, seen, ma, lat, mlat, st, to);
        $display("read 0x00000014 data=%h hit=%b memreq=%b maddr=%h misses=%0d", d, h, seen, ma, miss_count);
        checks++;
        if (to || d !== 32'hA1 || h !== 1'b0) begin
            errors++;
            $display("FAIL miss1_resp timeout=%b data=%h hit=%b want data=000000a1 hit=0", to, d, h);
        end
        checks++;
        if (!seen || ma !== 32'h10) begin
            errors++;
            $display("FAIL miss1_maddr seen=%b got %h want 00000010", seen, ma);
        end
        checks++;
        if (mlat !== 1) begin
            errors++;
            $display("FAIL miss1_memreq_latency got %0d want 1", mlat);
        end
        checks++;
        if (miss_count !== 32'd1 || hit_count !== 32'd0) begin
            errors++;
            $display("FAIL miss1_counts hits=%0d misses=%0d want 0/1", hit_count, miss_count);
        end
        do_read(32'h1C, 32'hEE, 0, 0, d, h, seen, ma, lat, mlat, st, to);
        $display("read 0x0000001c data=%h hit=%b memreq=%b lat=%0d hits=%0d", d, h, seen, lat, hit_count);
        checks++;
        if (to || d !== 32'hA3 || h !== 1'b1 || seen !== 1'b0) begin
            errors++;
            $display("FAIL hit_resp data=%h hit=%b memreq=%b want 000000a3 1 0", d, h, seen);
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL hit_latency got %0d want 2", lat);
        end
        checks++;
        if (hit_count !== 32'd1 || miss_count !== 32'd1) begin
            errors++;
            $display("FAIL hit_counts hits=%0d misses=%0d want 1/1", hit_count, miss_count);
        end
        checks++;
        @(posedge clk); #1;
        if (resp_valid !== 1'b0 || resp_data !== 32'hA3 || resp_hit !== 1'b1) begin
            errors++;
            $display("FAIL resp_hold valid=%b data=%h hit=%b want 0 000000a3 1", resp_valid, resp_data, resp_hit);
        end
    endtask

    task automatic test_conflict();
        logic [31:0] d, ma; logic h, seen, st, to; int lat, mlat;
        do_read(32'h114, 32'hB0, 0, 0, d, h, seen, ma, lat, mlat, st, to);
        $display("read 0x00000114 data=%h hit=%b maddr=%h", d, h, ma);
        checks++;
        if (to || d !== 32'hB1 || h !== 1'b0 || ma !== 32'h110) begin
            errors++;
            $display("FAIL conflict_fill data=%h hit=%b maddr=%h want 000000b1 0 00000110", d, h, ma);
        end
        do_read(32'h14, 32'hA0, 0, 0, d, h, seen, ma, lat, mlat, st, to);
        $display("reread 0x00000014 data=%h hit=%b misses=%0d", d, h, miss_count);
        checks++;
        if (to || !seen || d !== 32'hA1 || h !== 1'b0 || miss_count !== 32'd3) begin
            errors++;
            $display("FAIL conflict_evict memreq=%b data=%h hit=%b misses=%0d want 1 000000a1 0 3",
                     seen, d, h, miss_count);
        end
    endtask

    task automatic test_flush();
        logic [31:0] d, ma; logic h, seen, st, to; int lat, mlat;
        @(posedge clk); #1;
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h114;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready got %b want 0", req_ready);
        end
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_not_taken busy=%b want 0", busy);
        end
        // 0x14 was resident before the flush, so it must now miss.
        do_read(32'h14, 32'hA0, 0, 0, d, h, seen, ma, lat, mlat, st, to);
        $display("after flush read 0x00000014 data=%h hit=%b misses=%0d", d, h, miss_count);
        checks++;
        if (to || !seen || h !== 1'b0 || miss_count !== 32'd4) begin
            errors++;
            $display("FAIL flush_invalidate memreq=%b hit=%b misses=%0d want 1 0 4", seen, h, miss_count);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d, ma; logic h, seen, st, to; int lat, mlat;
        do_read(32'h34, 32'hC0, 5, 2, d, h, seen, ma, lat, mlat, st, to);
        $display("read 0x00000034 hold=5 gap=2 data=%h hit=%b maddr=%h stable=%b", d, h, ma, st);
        checks++;
        if (!st || ma !== 32'h30) begin
            errors++;
            $display("FAIL bp_stable stable=%b maddr=%h want 1 00000030", st, ma);
        end
        checks++;
        if (to || d !== 32'hC1 || h !== 1'b0) begin
            errors++;
            $display("FAIL bp_data data=%h hit=%b want 000000c1 0", d, h);
        end
        // Stray beat while idle must not disturb the cached line.
        mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD;
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_beat busy=%b resp_valid=%b want 0 0", busy, resp_valid);
        end
        do_read(32'h38, 32'hEE, 0, 0, d, h, seen, ma, lat, mlat, st, to);
        $display("read 0x00000038 data=%h hit=%b hits=%0d", d, h, hit_count);
        checks++;
        if (to || d !== 32'hC2 || h !== 1'b1 || hit_count !== 32'd2) begin
            errors++;
            $display("FAIL bp_rehit data=%h hit=%b hits=%0d want 000000c2 1 2", d, h, hit_count);
        end
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] d, ma; logic h, seen, st, to; int lat, mlat;
        logic got_req;
        got_req = 1'b0;
        req_valid = 1'b1; req_addr = 32'h24;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req_valid) begin got_req = 1'b1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (!got_req) begin
            errors++;
            $display("FAIL midrst_memreq no mem_req_valid within 20 cycles want 1");
        end
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_resp_valid = 1'b1; mem_resp_data = 32'hD0 + 32'(k);
            @(posedge clk); #1;
            mem_resp_valid = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, resp_valid, mem_req_valid, req_ready} !== 4'b0001 ||
            hit_count !== 32'd0 || miss_count !== 32'd0) begin
            errors++;
            $display("FAIL midrst_async busy/rv/mrv/rdy=%b hits=%0d misses=%0d want 0001 0 0",
                     {busy, resp_valid, mem_req_valid, req_ready}, hit_count, miss_count);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 2; k < 4; k++) begin
            mem_resp_valid = 1'b1; mem_resp_data = 32'hD0 + 32'(k);
            @(posedge clk); #1;
            mem_resp_valid = 1'b0;
        end
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_late_beats busy=%b resp_valid=%b want 0 0", busy, resp_valid);
        end
        do_read(32'h14, 32'hA0, 0, 0, d, h, seen, ma, lat, mlat, st, to);
        $display("after reset read 0x00000014 data=%h hit=%b misses=%0d hits=%0d", d, h, miss_count, hit_count);
        checks++;
        if (to || !seen || d !== 32'hA1 || h !== 1'b0 || miss_count !== 32'd1 || hit_count !== 32'd0) begin
            errors++;
            $display("FAIL midrst_restart memreq=%b data=%h hit=%b misses=%0d hits=%0d want 1 000000a1 0 1 0",
                     seen, d, h, miss_count, hit_count);
        end
        do_read(32'h24, 32'hE0, 0, 0, d, h, seen, ma, lat, mlat, st, to);
        $display("read 0x00000024 after interrupted refill data=%h hit=%b", d, h);
        checks++;
        if (to || !seen || h !== 1'b0 || d !== 32'hE1) begin
            errors++;
            $display("FAIL midrst_line_invalid memreq=%b hit=%b data=%h want 1 0 000000e1", seen, h, d);
        end
    endtask

    initial begin
        test_reset();
        test_miss_then_hit();
        test_conflict();
        test_flush();
        test_backpressure();
        test_reset_mid_refill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
